core_sequencer: RTL and testbench
=================================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, informational only; the sequencer never drives the PC value directly.
REQ-002 Parameter: TIMEOUT_CYCLES, 255, maximum wait cycles per handshake, range 1..255; used only with SEQ_TIMEOUT_EN.
REQ-003 Port: clk  input  1  single clock, rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 Port: pc, rs1_val, rs2_val, imm  input  32 each  current PC, register operands, decoded immediate.
REQ-006 Port: is_branch, is_jump, is_jalr, mem_read, mem_write, reg_write, halt_req  input  1 each  decoded controls; halt_req = ECALL/EBREAK.
REQ-007 Port: branch_type  input  3  branch funct3.
REQ-008 Port: imem_ready, dmem_ready  input  1 each  memory handshake completions.
REQ-009 Port: imem_req, dmem_req, ir_load, rf_we, pc_enable, pc_load  output  1 each  sequencing strobes.
REQ-010 Port: load_addr  output  32  PC load target.
REQ-011 Port: halted, misalign_err, bus_err  output  1 each  sticky status.

Function
REQ-012 States: RESET, FETCH, DECODE, EXEC, MEM, WB, HALT; all outputs are decoded from state and registers.
REQ-013 RESET: all outputs 0; unconditional transition to FETCH on the first clk after rst deasserts.
REQ-014 FETCH: imem_req=1 held until imem_ready; on imem_ready, ir_load=1 that same cycle, then go to DECODE. A zero-wait response (ready in the first FETCH cycle) is legal.
REQ-015 DECODE: one cycle; halt_req=1 goes to HALT, taking priority over every other decoded control; otherwise go to EXEC.
REQ-016 EXEC: one cycle; latches taken and target registers; mem_read|mem_write goes to MEM, else goes to WB.
REQ-017 Taken condition: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 not taken; is_jump or is_jalr is always taken.
REQ-018 Target: jalr gives (rs1_val+imm) & ~1; otherwise pc+imm. 32-bit wrap-around, carry discarded.
REQ-019 A taken target with bit[1]=1 goes from EXEC to HALT with misalign_err=1; no PC update, no rf_we.
REQ-020 MEM: dmem_req=1 held until dmem_ready, then go to WB; dmem_ready outside MEM is ignored, as is imem_ready outside FETCH.
REQ-021 WB: exactly one cycle; rf_we=reg_write, pc_enable=1; if taken, pc_load=1 with load_addr=target, else pc_load=0 and load_addr=0; then go to FETCH.
REQ-022 One instruction takes 4 cycles (FETCH, DECODE, EXEC, WB) plus one per MEM cycle, plus wait cycles.
REQ-023 HALT: absorbing state; halted=1; all strobes 0; exit only via reset.

Reset
REQ-024 Asserting rst forces RESET asynchronously at any point, including mid-handshake; imem_req/dmem_req drop in the same cycle.
REQ-025 Reset clears taken, target, wait counter, halted, misalign_err and bus_err.

Configuration
REQ-026 Macro SEQ_TIMEOUT_EN defined: an 8-bit wait counter counts FETCH/MEM cycles without ready and clears on each state entry.
REQ-027 If the wait counter reaches TIMEOUT_CYCLES, go to HALT with bus_err=1; a ready arriving on that same cycle wins and no error is raised.
REQ-028 Macro SEQ_TIMEOUT_EN undefined: no counter logic; waits are unbounded and bus_err is tied 0.

Structure
REQ-029 Shared package core_pkg SHALL hold the seq_state_t enum and the BR_BEQ..BR_BGEU funct3 constants.
REQ-030 Sub-module branch_unit SHALL contain the combinational compare and target calculation; core_sequencer SHALL contain the FSM, registers and counter.

Verification
REQ-031 ADD with zero-wait memories: strobes FETCH(imem_req, ir_load), DECODE, EXEC, WB(rf_we=1, pc_enable=1, pc_load=0); period 4 cycles.
REQ-032 BLT with rs1=0xFFFF_FFFF, rs2=1, pc=0x100, imm=0x20: WB gives pc_load=1, load_addr=0x120. BLTU with the same operands gives pc_load=0.
REQ-033 LW with dmem_ready delayed 3 cycles: dmem_req high for 4 cycles, single rf_we pulse in WB.
REQ-034 JALR with rs1=0x1001, imm=1 gives target 0x1002, bit1 set: HALT, misalign_err=1, no rf_we, no pc_load.
REQ-035 SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=4 and imem_ready never asserted: HALT with bus_err=1 after 4 FETCH cycles. Without the macro: still in FETCH after 1000 cycles.
REQ-036 rst asserted during a MEM wait: dmem_req falls the same cycle; after release, RESET then FETCH, with all status cleared.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the core sequencer: FSM state encoding and
// branch funct3 codes.
package core_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BT_W   = 3;
  localparam int unsigned WAIT_W = 8;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } seq_state_t;

  localparam logic [BT_W-1:0] BR_BEQ  = 3'b000;
  localparam logic [BT_W-1:0] BR_BNE  = 3'b001;
  localparam logic [BT_W-1:0] BR_BLT  = 3'b100;
  localparam logic [BT_W-1:0] BR_BGE  = 3'b101;
  localparam logic [BT_W-1:0] BR_BLTU = 3'b110;
  localparam logic [BT_W-1:0] BR_BGEU = 3'b111;

endpackage

// File: rtl/branch_unit.sv
// Combinational branch/jump resolution: taken decision and 32-bit target
// address (jalr target has bit 0 cleared).
module branch_unit
  import core_pkg::*;
(
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_val,
  input  logic [XLEN-1:0] i_rs2_val,
  input  logic [XLEN-1:0] i_imm,
  input  logic            i_is_branch,
  input  logic            i_is_jump,
  input  logic            i_is_jalr,
  input  logic [BT_W-1:0] i_branch_type,
  output logic            o_taken_c,
  output logic [XLEN-1:0] o_target_c
);

  logic            w_cond;
  logic [XLEN-1:0] w_sum;

  // funct3 compare; the two reserved encodings never take
  always_comb begin
    w_cond = 1'b0;
    case (i_branch_type)
      BR_BEQ:  w_cond = (i_rs1_val == i_rs2_val);
      BR_BNE:  w_cond = (i_rs1_val != i_rs2_val);
      BR_BLT:  w_cond = ($signed(i_rs1_val) <  $signed(i_rs2_val));
      BR_BGE:  w_cond = ($signed(i_rs1_val) >= $signed(i_rs2_val));
      BR_BLTU: w_cond = (i_rs1_val <  i_rs2_val);
      BR_BGEU: w_cond = (i_rs1_val >= i_rs2_val);
      default: w_cond = 1'b0;
    endcase
  end

  assign o_taken_c  = i_is_jump | i_is_jalr | (i_is_branch & w_cond);
  assign w_sum      = i_is_jalr ? (i_rs1_val + i_imm) : (i_pc + i_imm);
  assign o_target_c = i_is_jalr ? {w_sum[XLEN-1:1], 1'b0} : w_sum;

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer FSM (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Optional handshake timeout enabled by defining SEQ_TIMEOUT_EN.
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned     TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  input  logic            is_branch,
  input  logic            is_jump,
  input  logic            is_jalr,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            reg_write,
  input  logic            halt_req,
  input  logic [BT_W-1:0] branch_type,
  input  logic            imem_ready,
  input  logic            dmem_ready,
  output logic            imem_req,
  output logic            dmem_req,
  output logic            ir_load,
  output logic            rf_we,
  output logic            pc_enable,
  output logic            pc_load,
  output logic [XLEN-1:0] load_addr,
  output logic            halted,
  output logic            misalign_err,
  output logic            bus_err
);

  // Elaboration-time parameter sanity
  if ((TIMEOUT_CYCLES == 0) || (TIMEOUT_CYCLES > 32'd255)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("RESET_PC must be word aligned");
  end

  seq_state_t      r_state;
  seq_state_t      w_state_next;
  logic            r_taken;
  logic [XLEN-1:0] r_target;
  logic            r_misalign;
  logic            w_br_taken;
  logic [XLEN-1:0] w_br_target;
  logic            w_misaligned;
  logic            w_timeout;

  branch_unit u_branch (
    .i_pc          (pc),
    .i_rs1_val     (rs1_val),
    .i_rs2_val     (rs2_val),
    .i_imm         (imm),
    .i_is_branch   (is_branch),
    .i_is_jump     (is_jump),
    .i_is_jalr     (is_jalr),
    .i_branch_type (branch_type),
    .o_taken_c     (w_br_taken),
    .o_target_c    (w_br_target)
  );

  assign w_misaligned = w_br_taken & w_br_target[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_RESET;
    else      r_state <= w_state_next;
  end

  // Next-state logic; a ready always beats a same-cycle timeout
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RESET:  w_state_next = ST_FETCH;
      ST_FETCH: begin
        if (imem_ready)     w_state_next = ST_DECODE;
        else if (w_timeout) w_state_next = ST_HALT;
      end
      ST_DECODE: w_state_next = halt_req ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        if (w_misaligned)              w_state_next = ST_HALT;
        else if (mem_read | mem_write) w_state_next = ST_MEM;
        else                           w_state_next = ST_WB;
      end
      ST_MEM: begin
        if (dmem_ready)     w_state_next = ST_WB;
        else if (w_timeout) w_state_next = ST_HALT;
      end
      ST_WB:     w_state_next = ST_FETCH;
      ST_HALT:   w_state_next = ST_HALT;
      default:   w_state_next = ST_RESET;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    ir_load   = 1'b0;
    rf_we     = 1'b0;
    pc_enable = 1'b0;
    pc_load   = 1'b0;
    load_addr = '0;
    halted    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ready;
      end
      ST_MEM:   dmem_req = 1'b1;
      ST_WB: begin
        rf_we     = reg_write;
        pc_enable = 1'b1;
        pc_load   = r_taken;
        load_addr = r_taken ? r_target : '0;
      end
      ST_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  // Branch result captured in EXEC, consumed in WB
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_taken    <= 1'b0;
      r_target   <= '0;
      r_misalign <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_taken  <= w_br_taken;
      r_target <= w_br_target;
      if (w_misaligned) r_misalign <= 1'b1;
    end
  end

  assign misalign_err = r_misalign;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = WAIT_W + 1;

  logic [WAIT_W-1:0] r_wait;
  logic              r_bus_err;
  logic              w_waiting;

  assign w_waiting = ((r_state == ST_FETCH) & ~imem_ready) |
                     ((r_state == ST_MEM)   & ~dmem_ready);
  assign w_timeout = w_waiting &
                     ((CNT_W'(r_wait) + CNT_W'(1)) >= CNT_W'(TIMEOUT_CYCLES));

  // Wait counter restarts on every state entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait    <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_state_next != r_state) r_wait <= '0;
      else if (w_waiting)          r_wait <= r_wait + WAIT_W'(1);
      if (w_timeout) r_bus_err <= 1'b1;
    end
  end

  assign bus_err = r_bus_err;
`else
  assign w_timeout = 1'b0;
  assign bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: per-instruction vector table plus
// hand-written reset, halt and wait sequences.
`timescale 1ns/1ps
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, rs1_val, rs2_val, imm;
  logic        is_branch, is_jump, is_jalr, mem_read, mem_write, reg_write, halt_req;
  logic [2:0]  branch_type;
  logic        imem_ready, dmem_ready;
  logic        imem_req, dmem_req, ir_load, rf_we, pc_enable, pc_load;
  logic [31:0] load_addr;
  logic        halted, misalign_err, bus_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  core_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .pc(pc), .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
    .is_branch(is_branch), .is_jump(is_jump), .is_jalr(is_jalr),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .halt_req(halt_req), .branch_type(branch_type),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .ir_load(ir_load), .rf_we(rf_we),
    .pc_enable(pc_enable), .pc_load(pc_load), .load_addr(load_addr),
    .halted(halted), .misalign_err(misalign_err), .bus_err(bus_err)
  );

  // control bits: {br, jmp, jalr, mrd, mwr, rwe, hlt}
  localparam logic [6:0] BR = 7'b1000000, JMP = 7'b0100000, JALR = 7'b0010000,
                         MRD = 7'b0001000, MWR = 7'b0000100, RWE = 7'b0000010,
                         HLT = 7'b0000001;

  typedef struct {
    string       name;
    logic [31:0] pc, rs1, rs2, imm;
    logic [6:0]  ctl;
    logic [2:0]  bt;
    int          iwait, dwait;
    logic        noisy;
    int          e_cyc, e_pcl;
    logic [31:0] e_addr;
    int          e_rf, e_dreq;
    logic        e_halt, e_mis;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input string nm, input logic [31:0] p, r1, r2, im,
                              input logic [6:0] c, input logic [2:0] b,
                              input int iw, dw, input logic nz,
                              input int ecyc, epcl, input logic [31:0] eaddr,
                              input int erf, edr, input logic eh, em);
    vec_t v;
    v.name = nm; v.pc = p; v.rs1 = r1; v.rs2 = r2; v.imm = im; v.ctl = c; v.bt = b;
    v.iwait = iw; v.dwait = dw; v.noisy = nz; v.e_cyc = ecyc; v.e_pcl = epcl;
    v.e_addr = eaddr; v.e_rf = erf; v.e_dreq = edr; v.e_halt = eh; v.e_mis = em;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic set_instr(input vec_t v);
    pc = v.pc; rs1_val = v.rs1; rs2_val = v.rs2; imm = v.imm; branch_type = v.bt;
    {is_branch, is_jump, is_jalr, mem_read, mem_write, reg_write, halt_req} = v.ctl;
  endtask

  // Hold reset across one rising edge, check idle outputs, release on a falling edge
  task automatic do_reset(input string nm);
    @(negedge clk);
    rst = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    #1;
    check({nm, " reset strobes"},
          32'({imem_req, dmem_req, ir_load, rf_we, pc_enable, pc_load, halted, misalign_err, bus_err}),
          32'd0);
    check({nm, " reset load_addr"}, load_addr, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int cyc = 0, fcnt = 0, dcnt = 0, npcl = 0, nrf = 0, nir = 0, npe = 0;
    logic [31:0] addr = '0;
    logic hlt = 1'b0, done = 1'b0;
    set_instr(v);
    do_reset(v.name);
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (v.noisy) begin
        imem_ready = 1'b1; dmem_ready = 1'b1;
      end else begin
        imem_ready = imem_req && (fcnt == v.iwait);
        dmem_ready = dmem_req && (dcnt == v.dwait);
      end
      #1;
      if (npe > 0 && imem_req) done = 1'b1;
      else begin
        cyc++;
        fcnt += int'(imem_req); dcnt += int'(dmem_req);
        nir += int'(ir_load); nrf += int'(rf_we); npcl += int'(pc_load);
        if (pc_enable) begin npe++; addr = load_addr; end
        if (halted) begin hlt = 1'b1; done = 1'b1; end
      end
    end
    check({v.name, " completed in budget"}, 32'(done), 32'd1);
    check({v.name, " cycles"}, cyc, v.e_cyc);
    check({v.name, " ir_load pulses"}, nir, 1);
    check({v.name, " pc_load pulses"}, npcl, v.e_pcl);
    check({v.name, " load_addr"}, addr, v.e_addr);
    check({v.name, " rf_we pulses"}, nrf, v.e_rf);
    check({v.name, " dmem_req cycles"}, dcnt, v.e_dreq);
    check({v.name, " halted"}, 32'(hlt), 32'(v.e_halt));
    check({v.name, " misalign_err"}, 32'(misalign_err), 32'(v.e_mis));
  endtask

  initial begin
    int   cnt;
    vec_t v;
    rst = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    pc = '0; rs1_val = '0; rs2_val = '0; imm = '0; branch_type = '0;
    {is_branch, is_jump, is_jalr, mem_read, mem_write, reg_write, halt_req} = '0;

    //                name        pc            rs1           rs2           imm           ctl          bt      iw dw nz  cyc pcl addr          rf dr h  m
    vq.push_back(mk("ADD",        32'h0000_0000, 32'd5,        32'd7,        32'd0,        RWE,         3'b000, 0, 0, 0,  4, 0, 32'h0,        1, 0, 0, 0));
    vq.push_back(mk("BLT",        32'h0000_0100, 32'hFFFF_FFFF, 32'd1,       32'h20,       BR,          3'b100, 0, 0, 0,  4, 1, 32'h120,      0, 0, 0, 0));
    vq.push_back(mk("BLTU",       32'h0000_0100, 32'hFFFF_FFFF, 32'd1,       32'h20,       BR,          3'b110, 0, 0, 0,  4, 0, 32'h0,        0, 0, 0, 0));
    vq.push_back(mk("BEQ",        32'h0000_0200, 32'h55,       32'h55,       32'hFFFF_FFF0, BR,         3'b000, 0, 0, 0,  4, 1, 32'h1F0,      0, 0, 0, 0));
    vq.push_back(mk("BNE_eq",     32'h0000_0200, 32'h55,       32'h55,       32'h10,       BR,          3'b001, 0, 0, 0,  4, 0, 32'h0,        0, 0, 0, 0));
    vq.push_back(mk("BGE",        32'h0000_0040, 32'd1,        32'hFFFF_FFFF, 32'd8,       BR,          3'b101, 0, 0, 0,  4, 1, 32'h48,       0, 0, 0, 0));
    vq.push_back(mk("BGEU",       32'h0000_0040, 32'd1,        32'hFFFF_FFFF, 32'd8,       BR,          3'b111, 0, 0, 0,  4, 0, 32'h0,        0, 0, 0, 0));
    vq.push_back(mk("BR_010",     32'h0000_0040, 32'd1,        32'd2,        32'd8,        BR,          3'b010, 0, 0, 0,  4, 0, 32'h0,        0, 0, 0, 0));
    vq.push_back(mk("BR_011",     32'h0000_0040, 32'd1,        32'd2,        32'd8,        BR,          3'b011, 0, 0, 0,  4, 0, 32'h0,        0, 0, 0, 0));
    vq.push_back(mk("BNE_nt_odd", 32'h0000_0100, 32'h9,        32'h9,        32'd2,        BR,          3'b001, 0, 0, 0,  4, 0, 32'h0,        0, 0, 0, 0));
    vq.push_back(mk("JAL_wrap",   32'hFFFF_FFF0, 32'd0,        32'd0,        32'h20,       JMP | RWE,   3'b000, 1, 0, 0,  5, 1, 32'h10,       1, 0, 0, 0));
    vq.push_back(mk("JALR_ok",    32'h0000_5000, 32'h2000,     32'd0,        32'd9,        JALR | RWE,  3'b000, 0, 0, 0,  4, 1, 32'h2008,     1, 0, 0, 0));
    vq.push_back(mk("LW_wait3",   32'h0000_0000, 32'h400,      32'd0,        32'd4,        MRD | RWE,   3'b010, 0, 3, 0,  8, 0, 32'h0,        1, 4, 0, 0));
    vq.push_back(mk("SW_iwait2",  32'h0000_0000, 32'h400,      32'd3,        32'd4,        MWR,         3'b010, 2, 0, 0,  7, 0, 32'h0,        0, 1, 0, 0));
    vq.push_back(mk("LW_noisy",   32'h0000_0000, 32'h400,      32'd0,        32'd4,        MRD | RWE,   3'b010, 0, 0, 1,  5, 0, 32'h0,        1, 1, 0, 0));
    vq.push_back(mk("ECALL",      32'h0000_0000, 32'd0,        32'd0,        32'h8,        HLT | JMP | MRD | RWE, 3'b000, 0, 0, 0, 3, 0, 32'h0, 0, 0, 1, 0));
    vq.push_back(mk("BEQ_misal",  32'h0000_0100, 32'h7,        32'h7,        32'd6,        BR | RWE,    3'b000, 0, 0, 0,  4, 0, 32'h0,        0, 0, 1, 1));
    vq.push_back(mk("JALR_misal", 32'h0000_0000, 32'h1001,     32'd0,        32'd1,        JALR | RWE,  3'b000, 0, 0, 0,  4, 0, 32'h0,        0, 0, 1, 1));

    foreach (vq[i]) run_vec(vq[i]);

    // HALT is absorbing: nothing moves even with both readies high
    imem_ready = 1'b1; dmem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check("halt absorbing",
            32'({imem_req, dmem_req, ir_load, rf_we, pc_enable, pc_load, halted, misalign_err}),
            32'b0000_0011);
    end
    // Asynchronous reset mid-cycle clears sticky status immediately
    @(posedge clk); #2;
    rst = 1'b0; #1;
    check("status cleared by async reset", 32'({halted, misalign_err, bus_err}), 32'd0);
    @(negedge clk); rst = 1'b1;

    // Reset asserted during a MEM wait
    v = mk("LW_hold", 32'h0, 32'h400, 32'd0, 32'd4, MRD | RWE, 3'b010, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    set_instr(v);
    do_reset("LW_hold");
    imem_ready = 1'b1; dmem_ready = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20 && cnt < 3; k++) begin
      @(negedge clk); #1;
      cnt += int'(dmem_req);
    end
    check("mem wait reached", cnt, 3);
    @(posedge clk); #2;
    check("dmem_req held while waiting", 32'(dmem_req), 32'd1);
    rst = 1'b0; #1;
    check("dmem_req drops on reset", 32'({dmem_req, imem_req}), 32'd0);
    @(negedge clk); rst = 1'b1; #1;
    check("RESET after release", 32'({imem_req, dmem_req, halted}), 32'd0);
    @(negedge clk); #1;
    check("FETCH after RESET", 32'(imem_req), 32'd1);
    check("status clear after reset", 32'({halted, misalign_err, bus_err}), 32'd0);

    // imem_ready never arrives
    set_instr(vq[0]);
    do_reset("no_ready");
    imem_ready = 1'b0; dmem_ready = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (halted) break;
      cnt += int'(imem_req);
    end
    check("timeout fetch cycles", cnt, 4);
    check("timeout halted", 32'(halted), 32'd1);
    check("timeout bus_err", 32'(bus_err), 32'd1);
`else
    repeat (1000) @(negedge clk);
    #1;
    check("unbounded wait still fetching", 32'(imem_req), 32'd1);
    check("unbounded wait no ir_load", 32'(ir_load), 32'd0);
    check("unbounded wait status", 32'({halted, bus_err}), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
